// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared state encoding, R/W polarity and sizing helper for the SPI memory FSM
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_SHIFT  = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } spiState_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter with synchronous clear and terminal-edge compare
module spi_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             isLast
);

  logic [WIDTH-1:0] count;

  // Clear wins over enable so a state entry always starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  // High when the next enabled edge is the term-th one, so the FSM leaves exactly on it.
  assign isLast = (count == term - WIDTH'(1));

endmodule

// File: rtl/spi_mem_fsm.sv
// rtl/spi_mem_fsm.sv - SPI memory slave control FSM; optional burst mode via SPI_MEM_FSM_BURST_EN
import spi_mem_pkg::*;

module spi_mem_fsm #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
  output logic addr_latch_we,
  output logic shift_reg_we,
  output logic miso_enable,
  output logic data_mem_we,
  output logic addr_inc,
  output logic busy
);

  localparam int CNT_W = $clog2(maxInt(ADDR_WIDTH + 1, DATA_WIDTH) + 1);
  localparam logic [CNT_W-1:0] HDR_TERM  = CNT_W'(ADDR_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_WIDTH);

  spiState_t        state;
  spiState_t        nextState;
  logic             incPhase;
  logic             nextIncPhase;
  logic             cntClr;
  logic             cntEn;
  logic             cntLast;
  logic [CNT_W-1:0] cntTerm;

  spi_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bitCnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cntClr),
    .en     (cntEn),
    .term   (cntTerm),
    .isLast (cntLast)
  );

  // State register plus the burst-read flag marking the address-increment cycle of READ_LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      incPhase <= 1'b0;
    end else begin
      state    <= nextState;
      incPhase <= nextIncPhase;
    end
  end

  // Next-state logic; cs_n high aborts from any state and each state watches only its own strobe.
  always_comb begin
    nextState    = state;
    nextIncPhase = 1'b0;
    cntEn        = 1'b0;
    cntTerm      = HDR_TERM;
    if (cs_n) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: nextState = GET_ADDR;
        GET_ADDR: begin
          cntEn   = sclk_rise;
          cntTerm = HDR_TERM;
          if (sclk_rise && cntLast) nextState = GOT_ADDR;
        end
        GOT_ADDR: nextState = (rw_bit == RW_READ) ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD: nextState = incPhase ? READ_LOAD : READ_SHIFT;
        READ_SHIFT: begin
          cntEn   = sclk_fall;
          cntTerm = DATA_TERM;
          if (sclk_fall && cntLast) begin
`ifdef SPI_MEM_FSM_BURST_EN
            nextState    = READ_LOAD;
            nextIncPhase = 1'b1;
`else
            nextState    = DONE;
`endif
          end
        end
        WRITE_SHIFT: begin
          cntEn   = sclk_rise;
          cntTerm = DATA_TERM;
          if (sclk_rise && cntLast) nextState = WRITE_COMMIT;
        end
`ifdef SPI_MEM_FSM_BURST_EN
        WRITE_COMMIT: nextState = WRITE_SHIFT;
`else
        WRITE_COMMIT: nextState = DONE;
`endif
        DONE: nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Any state change restarts the edge count, including aborts and burst re-entries.
  assign cntClr = (nextState != state);

  // Outputs decode the registered state only, so they change exactly one clk after the cause.
  assign addr_latch_we = (state == GOT_ADDR);
  assign shift_reg_we  = (state == READ_LOAD) && !incPhase;
  assign miso_enable   = (state == READ_SHIFT);
  assign data_mem_we   = (state == WRITE_COMMIT);
  assign busy          = (state != IDLE);
`ifdef SPI_MEM_FSM_BURST_EN
  assign addr_inc      = ((state == READ_LOAD) && incPhase) || (state == WRITE_COMMIT);
`else
  assign addr_inc      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_fsm.sv
// tb/tb_spi_mem_fsm.sv - randomized transaction-level bench for spi_mem_fsm (narrow and wide instances)
module tb_spi_mem_fsm;
  import spi_mem_pkg::*;

`ifdef SPI_MEM_FSM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic cs_n      = 1'b1;
  logic sclk_rise = 1'b0;
  logic sclk_fall = 1'b0;
  logic rw_bit    = 1'b0;

  logic alwN, srwN, misoN, dmwN, incN, busyN;
  logic alwW, srwW, misoW, dmwW, incW, busyW;
  logic [5:0] outN, outW, outSel;

  int  checks  = 0;
  int  errors  = 0;
  int  edgeIdx = 0;
  bit  sel     = 1'b0;
  int  obsAlw[$], obsSrw[$], obsMiso[$], obsDmw[$], obsInc[$], obsBusy[$];

  spi_mem_fsm dutN (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .rw_bit(rw_bit), .addr_latch_we(alwN), .shift_reg_we(srwN), .miso_enable(misoN),
    .data_mem_we(dmwN), .addr_inc(incN), .busy(busyN)
  );

  spi_mem_fsm #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) dutW (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .rw_bit(rw_bit), .addr_latch_we(alwW), .shift_reg_we(srwW), .miso_enable(misoW),
    .data_mem_we(dmwW), .addr_inc(incW), .busy(busyW)
  );

  assign outN   = {alwN, srwN, misoN, dmwN, incN, busyN};
  assign outW   = {alwW, srwW, misoW, dmwW, incW, busyW};
  assign outSel = sel ? outW : outN;

  always #5 clk = ~clk;

  // Index of the most recent rising clk edge.
  always @(posedge clk) edgeIdx <= edgeIdx + 1;

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmpQ(input string tag, input int obs[$], input int exp[$]);
    checkEq({tag, ".count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      checkEq($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
  endtask

  // One clk of stimulus; outputs observed on the following falling edge are logged by edge index.
  task automatic step(input logic r, input logic f, input logic c);
    sclk_rise = r;
    sclk_fall = f;
    cs_n      = c;
    @(posedge clk);
    @(negedge clk);
    if (outSel[5]) obsAlw.push_back(edgeIdx);
    if (outSel[4]) obsSrw.push_back(edgeIdx);
    if (outSel[3]) obsMiso.push_back(edgeIdx);
    if (outSel[2]) obsDmw.push_back(edgeIdx);
    if (outSel[1]) obsInc.push_back(edgeIdx);
    if (outSel[0]) obsBusy.push_back(edgeIdx);
  endtask

  // Full SPI transaction with mode-0 SCLK; nData data edges, last one optionally coincident with cs_n rising.
  task automatic runTxn(input string name, input bit wide, input bit rd, input int nData, input bit coin);
    int aw, dw, hp, nR, dataCnt, s, k, c, mStart;
    bit stop, isRise, isData, isLast, killed;
    int expAlw[$], expSrw[$], expMiso[$], expDmw[$], expInc[$], expBusy[$];
    aw = wide ? 15 : 7;
    dw = wide ? 16 : 8;
    sel = wide;
    rw_bit = rd ? RW_READ : RW_WRITE;
    obsAlw.delete(); obsSrw.delete(); obsMiso.delete();
    obsDmw.delete(); obsInc.delete(); obsBusy.delete();
    hp = $urandom_range(7, 4);
    step(1'b0, 1'b0, 1'b0);
    s = edgeIdx;
    repeat ($urandom_range(3, 0)) step(1'b0, 1'b0, 1'b0);
    nR = 0; dataCnt = 0; stop = 1'b0; k = -1; mStart = -1;
    while (!stop) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (!stop) begin
          isRise = (ph == 0);
          if (isRise) nR++;
          isData = rd ? (!isRise && nR >= aw + 1) : (isRise && nR > aw + 1);
          if (isData) dataCnt++;
          isLast = isData && (dataCnt == nData);
          killed = isLast && coin;
          step(isRise, !isRise, killed);
          if (isRise && nR == aw + 1) begin
            k = edgeIdx;
            expAlw.push_back(k);
            if (rd) begin
              expSrw.push_back(k + 1);
              mStart = k + 2;
            end
          end
          if (isData && !killed && (dataCnt % dw == 0) && (BURST || dataCnt == dw)) begin
            if (rd) begin
              for (int i = mStart; i < edgeIdx; i++) expMiso.push_back(i);
              mStart = -1;
              if (BURST) begin
                expInc.push_back(edgeIdx);
                expSrw.push_back(edgeIdx + 1);
                mStart = edgeIdx + 2;
              end
            end else begin
              expDmw.push_back(edgeIdx);
              if (BURST) expInc.push_back(edgeIdx);
            end
          end
          if (isLast) stop = 1'b1;
          if (!killed) repeat (hp - 1) step(1'b0, 1'b0, 1'b0);
        end
      end
    end
    if (coin) begin
      c = edgeIdx;
    end else begin
      step(1'b0, 1'b0, 1'b1);
      c = edgeIdx;
    end
    if (mStart >= 0) for (int i = mStart; i < c; i++) expMiso.push_back(i);
    for (int i = s; i < c; i++) expBusy.push_back(i);
    step(1'b0, 1'b0, 1'b1);
    cmpQ({name, ".addr_latch_we"}, obsAlw, expAlw);
    cmpQ({name, ".shift_reg_we"}, obsSrw, expSrw);
    cmpQ({name, ".miso_enable"}, obsMiso, expMiso);
    cmpQ({name, ".data_mem_we"}, obsDmw, expDmw);
    cmpQ({name, ".addr_inc"}, obsInc, expInc);
    cmpQ({name, ".busy"}, obsBusy, expBusy);
  endtask

  initial begin
    int dw;
    bit wide, rd, coin;

    // Reset state of both instances
    @(negedge clk);
    @(negedge clk);
    checkEq("reset.outsNarrow", int'(outN), 0);
    checkEq("reset.outsWide", int'(outW), 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);

    // Directed transactions on the default widths
    runTxn("write8", 1'b0, 1'b0, 8, 1'b0);
    runTxn("read8", 1'b0, 1'b1, 8, 1'b0);
    runTxn("abortAfter3", 1'b0, 1'b0, 3, 1'b0);
    runTxn("abortCoin8", 1'b0, 1'b0, 8, 1'b1);
    runTxn("write16", 1'b0, 1'b0, 16, 1'b0);
    runTxn("read16", 1'b0, 1'b1, 16, 1'b0);

    // Reset asserted in GET_ADDR after three header rises
    sel = 1'b0;
    obsBusy.delete();
    step(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end
    checkEq("rstMid.busyBefore", int'(busyN), 1);
    #2 reset = 1'b1;
    #1;
    checkEq("rstMid.outs", int'(outN), 0);
    cs_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    checkEq("rstMid.outsAfter", int'(outN), 0);
    runTxn("postReset", 1'b0, 1'b0, 8, 1'b0);

    // Width sweep on the 15/16 instance
    runTxn("wideWrite", 1'b1, 1'b0, 16, 1'b0);
    runTxn("wideRead", 1'b1, 1'b1, 32, 1'b0);
    runTxn("wideAbortCoin", 1'b1, 1'b0, 16, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      wide = 1'($urandom_range(1, 0));
      rd   = 1'($urandom_range(1, 0));
      dw   = wide ? 16 : 8;
      coin = ($urandom_range(3, 0) == 0);
      runTxn($sformatf("rnd%0d", i), wide, rd, $urandom_range(2 * dw, 1), coin);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_fsm.md
# spi_mem_fsm

Parametrised control FSM for the SPI memory slave. It runs on the system clock, consumes single-cycle SCLK edge strobes and a synchronised chip-select, and sequences the address latch, shift-register parallel load, MISO tri-state enable and data-memory write. It generalises address and data widths and adds optional burst transfers with address auto-increment. It sits between the input conditioners/edge detector and the datapath (address latch, shift register, data memory).

## Interface
- ADDR_WIDTH, 7: address bits per transaction; the R/W bit follows them, so the header is ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8: bits per data word.
- clk  input  1  system clock; all state changes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs_n  input  1  synchronised chip select, active low.
- sclk_rise  input  1  one-clk strobe on each SCLK rising edge.
- sclk_fall  input  1  one-clk strobe on each SCLK falling edge.
- rw_bit  input  1  shift-register bit 0 (R/W: 1=read, 0=write); valid once the header is complete.
- addr_latch_we  output  1  one-clk pulse: latch the address.
- shift_reg_we  output  1  one-clk pulse: parallel-load the shift register from memory.
- miso_enable  output  1  drive MISO.
- data_mem_we  output  1  one-clk pulse: write the shift-register word to memory.
- addr_inc  output  1  one-clk pulse: increment the address latch (burst only).
- busy  output  1  high whenever state != IDLE.

## Operation
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
- Bit counter width: $clog2(max(ADDR_WIDTH+1, DATA_WIDTH)+1). It clears to 0 on every state entry.
- IDLE: when cs_n=0, go to GET_ADDR.
- GET_ADDR: count sclk_rise. On the (ADDR_WIDTH+1)th rise, go to GOT_ADDR.
- GOT_ADDR: lasts one clk, with addr_latch_we=1. Sample rw_bit: 1 goes to READ_LOAD, 0 goes to WRITE_SHIFT.
- READ_LOAD: lasts one clk, with shift_reg_we=1. Then go to READ_SHIFT.
- READ_SHIFT:
  - miso_enable=1 throughout.
  - Count sclk_fall. On the DATA_WIDTH-th fall, go to DONE (burst: see Configuration).
- WRITE_SHIFT: count sclk_rise. On the DATA_WIDTH-th rise, go to WRITE_COMMIT.
- WRITE_COMMIT: lasts one clk, with data_mem_we=1. Then go to DONE.
- DONE:
  - All strobes are 0.
  - SCLK edges are ignored.
  - Stay until cs_n=1.
- Abort: cs_n=1 in any state forces IDLE at the next clk edge and clears the counter.
- Priority:
  - cs_n=1 beats any edge strobe in the same cycle, so no commit occurs.
  - reset beats everything.
- Each state uses only its own edge strobe. The other strobe is ignored, and simultaneous rise/fall is therefore harmless.
- Counter never wraps: transitions occur exactly at the terminal count.

## Timing
- All outputs are registered (decoded from the state register).
- Reset value: every output 0, state IDLE, counter 0.
- addr_latch_we is high in the clk cycle after the cycle in which the terminal header sclk_rise is sampled.
- shift_reg_we is high 1 clk after addr_latch_we.
- miso_enable rises 1 clk after shift_reg_we.
- miso_enable falls 1 clk after the terminal sclk_fall is sampled.
- data_mem_we is high 1 clk after the terminal data sclk_rise is sampled.
- Abort latency: outputs are 0 one clk after cs_n=1 is sampled.
- Requirement on the environment: SCLK half-period ≥ 4 clk, so a read reload completes before the next fall.

## Configuration
- SPI_MEM_FSM_BURST_EN defined (burst mode):
  - READ_SHIFT terminal fall: addr_inc=1 for one clk, then READ_LOAD. The word at the new address loads 1 clk after addr_inc.
  - WRITE_COMMIT: addr_inc=1 in the same clk as data_mem_we. Memory writes the pre-increment address. Then return to WRITE_SHIFT.
  - The transaction ends only on cs_n=1.
- Not defined:
  - addr_inc is tied 0.
  - Terminal data edges go to DONE.
  - One word per transaction.

## Structure
- Shared package spi_mem_pkg holds:
  - the state typedef and its 3-bit encodings (IDLE=0 … DONE=7);
  - the R/W bit polarity constants (RW_READ=1, RW_WRITE=0).
- Sub-module spi_bit_counter holds the parametrised width, clear input, count-enable input and terminal-count compare output. The FSM instantiates it once.

## Test plan
Defaults unless stated: ADDR_WIDTH=7, DATA_WIDTH=8.
- Reset: assert reset mid-GET_ADDR after 3 rises -> all outputs 0 immediately; busy=0; the next transaction behaves normally.
- Write: cs_n=0, 8 header rises with rw_bit=0, then 8 data rises -> addr_latch_we pulses once (1 clk); data_mem_we pulses once (1 clk); miso_enable stays 0; busy=1 until cs_n=1.
- Read: header with rw_bit=1 -> shift_reg_we 1 clk after addr_latch_we; miso_enable high for exactly 8 sclk_fall; no data_mem_we.
- Abort: cs_n=1 after 3 data rises of a write, and separately cs_n=1 coincident with the 8th data rise -> data_mem_we never asserts; IDLE the next clk.
- Burst write (macro on): 16 data rises -> 2 data_mem_we pulses, each coincident with an addr_inc pulse. Macro off: the same stimulus gives 1 data_mem_we, 0 addr_inc, state DONE.
- Width sweep: ADDR_WIDTH=15, DATA_WIDTH=16 -> addr_latch_we after the 16th rise; data_mem_we after 16 more rises.
